// File: rtl/uart_word_loader_if.sv
// uart_word_loader_if
//   Bundles the byte stream from the UART receiver with the instruction-memory
//   write port and the loader status lines.
//
//   Handshake: rx_valid is a one-cycle strobe qualifying rx_data. There is no
//   ready; the loader consumes every strobe. mem_we is a one-cycle strobe
//   qualifying mem_addr/mem_wdata. load_done is a one-cycle pulse, load_busy
//   and load_error are levels.
//
//   Modports:
//     master - byte source / memory side (drives rx_*, observes the rest)
//     slave  - the loader (consumes rx_*, drives mem_* and load_*)
interface uart_word_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  load_busy;
  logic                  load_done;
  logic                  load_error;

  modport master (
    output rx_data, rx_valid,
    input  mem_we, mem_addr, mem_wdata, load_busy, load_done, load_error
  );

  modport slave (
    input  rx_data, rx_valid,
    output mem_we, mem_addr, mem_wdata, load_busy, load_done, load_error
  );
endinterface

// File: rtl/uart_word_loader.sv
// uart_word_loader
//   Parses a framed byte stream from the UART receiver
//     SYNC, LEN_LO, LEN_HI, LEN x 4 data bytes (little endian), [CHK]
//   and writes each assembled 32-bit word to instruction memory at
//   consecutive word addresses starting at 0.
//
//   Optional feature macro: UART_LOADER_CHECKSUM_EN
//     defined   - a trailing CHK byte must equal the XOR of LEN_LO, LEN_HI
//                 and all data bytes.
//     undefined - no CHECK state, no XOR logic; frame ends on last data byte.
//
//   Ports:
//     clk       - clock, all logic on posedge
//     reset     - synchronous, active low
//     bus       - uart_word_loader_if.slave (rx_data/rx_valid in,
//                 mem_we/mem_addr/mem_wdata, load_busy/load_done/load_error out)
//     dbg_state - current FSM state (0 = IDLE)
module uart_word_loader #(
  parameter int         ADDR_WIDTH   = 10,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 2_000_000
) (
  input  logic                clk,
  input  logic                reset,
  uart_word_loader_if.slave   bus,
  output logic [2:0]          dbg_state
);

  localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);
  // Largest legal frame length, kept 17 bits wide so 2^16 is representable.
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
`ifdef UART_LOADER_CHECKSUM_EN
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4
`else
    S_DATA   = 3'd3
`endif
  } state_t;

  state_t        state;
  logic [15:0]   len;
  logic [15:0]   word_cnt;
  logic [1:0]    byte_idx;
  logic [23:0]   word_sh;   // bytes 0..2 of the word being assembled
  logic [TW-1:0] timer;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]    chk;
`endif

  // Newest byte enters at the top, so byte 0 lands in bits [7:0] after 4 bytes.
  logic [31:0] word_next;
  logic [15:0] len_full;
  logic [15:0] word_cnt_inc;

  assign word_next    = {bus.rx_data, word_sh};
  assign len_full     = {bus.rx_data, len[7:0]};
  assign word_cnt_inc = word_cnt + 16'd1;
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      len            <= '0;
      word_cnt       <= '0;
      byte_idx       <= '0;
      word_sh        <= '0;
      timer          <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      chk            <= '0;
`endif
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.load_busy  <= 1'b0;
      bus.load_done  <= 1'b0;
      bus.load_error <= 1'b0;
    end else begin
      bus.mem_we    <= 1'b0;
      bus.load_done <= 1'b0;

      if (state == S_IDLE || bus.rx_valid) timer <= '0;
      else                                 timer <= timer + 1'b1;

      // A byte arriving in the expiry cycle takes priority over the timeout.
      if (bus.rx_valid) begin
        case (state)
          S_IDLE: begin
            if (bus.rx_data == SYNC_BYTE) begin
              bus.load_error <= 1'b0;
              bus.load_busy  <= 1'b1;
              byte_idx       <= '0;
              word_cnt       <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
              chk            <= '0;
`endif
              state          <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            len[7:0] <= bus.rx_data;
`ifdef UART_LOADER_CHECKSUM_EN
            chk      <= chk ^ bus.rx_data;
`endif
            state    <= S_LEN_HI;
          end
          S_LEN_HI: begin
            len <= len_full;
`ifdef UART_LOADER_CHECKSUM_EN
            chk <= chk ^ bus.rx_data;
`endif
            if ({1'b0, len_full} > MAX_LEN) begin
              bus.load_error <= 1'b1;
              bus.load_busy  <= 1'b0;
              state          <= S_IDLE;
            end else if (len_full == 16'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
              state          <= S_CHECK;
`else
              bus.load_done  <= 1'b1;
              bus.load_busy  <= 1'b0;
              state          <= S_IDLE;
`endif
            end else begin
              state          <= S_DATA;
            end
          end
          S_DATA: begin
            word_sh  <= word_next[31:8];
            byte_idx <= byte_idx + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
            chk      <= chk ^ bus.rx_data;
`endif
            if (byte_idx == 2'd3) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
              bus.mem_wdata <= word_next;
              word_cnt      <= word_cnt_inc;
              if (word_cnt_inc == len) begin
`ifdef UART_LOADER_CHECKSUM_EN
                state         <= S_CHECK;
`else
                bus.load_done <= 1'b1;
                bus.load_busy <= 1'b0;
                state         <= S_IDLE;
`endif
              end
            end
          end
`ifdef UART_LOADER_CHECKSUM_EN
          S_CHECK: begin
            if (bus.rx_data == chk) bus.load_done  <= 1'b1;
            else                    bus.load_error <= 1'b1;
            bus.load_busy <= 1'b0;
            state         <= S_IDLE;
          end
`endif
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE && timer == TIMER_LAST) begin
        bus.load_error <= 1'b1;
        bus.load_busy  <= 1'b0;
        state          <= S_IDLE;
      end
    end
  end

endmodule
